// File: rtl/bus_map.sv
// CPU address decoder and wait-state sequencer: maps a flat CPU bus onto N
// regions, each with its own base, size and wait-state count.
module bus_map #(
    parameter int unsigned         AW    = 20,
    parameter int unsigned         N     = 5,
    parameter logic [N*AW-1:0]     BASE  = {20'hFF000, 20'hA0000, 20'hB8000, 20'h40000, 20'h00000},
    parameter logic [N*AW-1:0]     SIZE  = {20'h01000, 20'h02000, 20'h02000, 20'h08000, 20'h40000},
    parameter logic [N*4-1:0]      WAITS = {N{4'd1}}
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          req,
    input  logic [AW-1:0] a,
    input  logic [7:0]    d,
    input  logic          w,
    output logic          ready,
    output logic [7:0]    q,
    output logic          miss,
    output logic [N-1:0]  sel,
    output logic [AW-1:0] ra,
    output logic [7:0]    rd,
    output logic          rw,
    input  logic [N*8-1:0] rq
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [IW-1:0] idx;
    logic          wr_l;
    logic          miss_arm;

    logic          hit;
    logic [IW-1:0] hit_idx;
    logic [AW-1:0] lo;
    logic [AW:0]   top;
    logic [AW-1:0] hit_base;
    logic [3:0]    hit_waits;
    logic [N-1:0]  hit_sel;

    // Limit computed one bit wider so a region ending at the top of memory does not wrap.
    // Scanning upward and keeping the first hit gives the lowest index priority.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        lo      = '0;
        top     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            lo  = BASE[k*AW +: AW];
            top = {1'b0, lo} + {1'b0, SIZE[k*AW +: AW]};
            if (!hit && (a >= lo) && ({1'b0, a} < top)) begin
                hit     = 1'b1;
                hit_idx = IW'(k);
            end
        end
    end

    assign hit_base  = BASE[hit_idx*AW +: AW];
    assign hit_waits = WAITS[hit_idx*4 +: 4];
    assign hit_sel   = N'(1) << hit_idx;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            wr_l     <= 1'b0;
            miss_arm <= 1'b0;
            sel      <= '0;
            ra       <= '0;
            rd       <= '0;
            rw       <= 1'b0;
            ready    <= 1'b0;
            miss     <= 1'b0;
            q        <= 8'hFF;
        end else begin
            ready <= 1'b0;
            miss  <= 1'b0;
            rw    <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (req) begin
                        wr_l <= w;
                        if (hit) begin
                            state <= S_WAIT;
                            idx   <= hit_idx;
                            cnt   <= hit_waits;
                            sel   <= hit_sel;
                            ra    <= a - hit_base;
                            rd    <= d;
                            // rw is registered, so it is raised on the edge entering the final WAIT cycle
                            rw    <= w && (hit_waits == 4'd0);
                        end else begin
                            state    <= S_DONE;
                            miss_arm <= 1'b1;
                            if (!w) q <= 8'hFF;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                        rw  <= wr_l && (cnt == 4'd1);
                    end else begin
                        state <= S_DONE;
                        sel   <= '0;
                        if (!wr_l) q <= rq[idx*8 +: 8];
                    end
                end
                S_DONE: begin
                    ready    <= 1'b1;
                    miss     <= miss_arm;
                    miss_arm <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/bus_map.md
BUS_MAP -- requirements
Module: bus_map

Interface
REQ-001 Parameter AW, 20, CPU address width in bits.
REQ-002 Parameter N, 5, number of mapped regions (1..8).
REQ-003 Parameter BASE, {FF000,A0000,B8000,40000,00000}, packed N*AW region base addresses; region k occupies slice k.
REQ-004 Parameter SIZE, {01000,02000,02000,08000,40000}, packed N*AW region sizes in bytes, each nonzero.
REQ-005 Parameter WAITS, all 4'd1, packed N*4 wait-state count per region (0..15).
REQ-006 clock  in  1  system clock; all state changes on its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 req  in  1  CPU access request; sampled only in IDLE.
REQ-009 a  in  AW  CPU byte address.
REQ-010 d  in  8  CPU write data.
REQ-011 w  in  1  1 = write, 0 = read; sampled with req.
REQ-012 ready  out  1  one-cycle pulse: access complete.
REQ-013 q  out  8  read data to CPU, held until the next completed read.
REQ-014 miss  out  1  one-cycle pulse with ready when the address matched no region.
REQ-015 sel  out  N  one-hot region select, held during the access.
REQ-016 ra  out  AW  region-relative address (a - BASE[k]), held during the access.
REQ-017 rd  out  8  latched write data to regions.
REQ-018 rw  out  1  region write strobe, one cycle.
REQ-019 rq  in  N*8  per-region read data, slice k from region k.

Function
REQ-020 Region k hits when BASE[k] <= a < BASE[k]+SIZE[k]; the sum is computed in AW+1 bits, so FF000+01000 covers FFFFF with no wrap.
REQ-021 On overlapping hits the lowest index wins; sel never carries more than one bit.
REQ-022 States: IDLE, WAIT, DONE.
REQ-023 IDLE, req=1, hit on k: latch a/d/w, load counter with WAITS[k], set sel[k], ra, rd; go to WAIT.
REQ-024 IDLE, req=1, no hit: go to DONE with miss armed, sel stays 0; a read loads q=8'hFF; a write is discarded.
REQ-025 WAIT: while counter != 0, decrement; when counter == 0, go to DONE, and in that cycle: for a read, capture rq slice k into q; for a write, assert rw for exactly this one cycle.
REQ-026 A region with WAITS=0 spends one cycle in WAIT, so sel is always high for WAITS[k]+1 cycles.
REQ-027 DONE: ready=1 (and miss=1 if armed) for one cycle, sel cleared, return to IDLE.
REQ-028 Latency, req sampled at edge T: hit completes with ready high after edge T+WAITS[k]+2; miss completes with ready high after edge T+1.
REQ-029 req is ignored in WAIT and DONE; back-to-back requests are accepted from the first IDLE cycle after ready.
REQ-030 Changes on a, d or w after acceptance do not affect ra, rd, rw or q of the accepted access.
REQ-031 A write leaves q unchanged.

Reset
REQ-032 While rst_n=0, regardless of clock: state=IDLE, counter=0, sel=0, ra=0, rd=0, rw=0, ready=0, miss=0, q=8'hFF.
REQ-033 Reset asserted mid-access aborts it: no rw, no ready, and q is not updated; after release the block accepts a new req in the first IDLE cycle.

Verification
REQ-034 Read at a=B8005, WAITS[2]=1, rq slice2=8'h41 -> sel=00100 for 2 cycles, ra=00005, q=41, ready 3 cycles after the req edge, miss=0.
REQ-035 Write at a=40000, d=8'h5A, WAITS[1]=1 -> sel=00010, ra=00000, rd=5A, rw one cycle in the second WAIT cycle, q unchanged.
REQ-036 Reads at 47FFF and 48000 -> first hits region 1 with ra=07FFF; second returns q=FF, miss=1, ready one cycle after req, sel stays 0.
REQ-037 Read at FFFFF -> region 4 hit, ra=00FFF, no wrap false miss; with WAITS[4]=0, sel is high for exactly 1 cycle.
REQ-038 Overlap build: BASE1=00000 duplicates region 0; read at 00010 -> sel=00001 only.
REQ-039 rst_n pulled low one cycle into WAIT of a write -> rw never asserts, outputs match REQ-032; next req completes normally.
